nn_seq_controller: RTL and testbench
====================================

# nn_seq_controller

Sequenced 2-3-1 neural-network engine. A single shared multiply-accumulate neuron datapath is time-multiplexed across all six neurons (two input, three hidden, one output), with intermediate activations held in registers. Weights and biases come from an internal configuration register file. Inferences are accepted and returned through valid/ready handshakes, so the block can replace the flat combinational network behind a streaming interface.

## Interface
Parameters:
- none; all widths are fixed: operands 2b, biases 4b, accumulator 6b.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  5  config address:
  - 0..10: w1,w2,w11,w12,w13,w21,w22,w23,w01,w02,w03.
  - 11..16: b1..b6.
  - 17..31: ignored.
- cfg_data  in  4  write data; weights use [1:0].
- cfg_err  out  1  one-cycle pulse when a write is dropped because the block is busy.
- in_valid  in  1  input pair valid.
- in_ready  out  1  high only in IDLE.
- in_x1, in_x2  in  2  network inputs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  2  network output.
- busy  out  1  high in RUN.

## Operation
- States and transitions:
  - IDLE → RUN on in_valid&in_ready; x1 and x2 are latched on that edge and step is cleared to 0.
  - RUN performs steps 0..10, one per cycle.
  - RUN → DONE on the step-10 edge.
  - DONE → IDLE on out_valid&out_ready.
- Step schedule (operand pair → destination). The first step of each neuron loads acc = bias + product; later steps do acc += product.
  - Step 0: x1·w1 + b1 → f1.
  - Step 1: x2·w2 + b2 → f2.
  - Steps 2,3: f1·w11, f2·w21 + b3 → f3.
  - Steps 4,5: f1·w12, f2·w22 + b4 → f4.
  - Steps 6,7: f1·w13, f2·w23 + b5 → f5.
  - Steps 8,9,10: f3·w01, f4·w02, f5·w03 + b6 → out_y.
- Arithmetic:
  - All values are unsigned.
  - Products are 4b.
  - The acc is 6b; its maximum value of 42 cannot overflow.
- Activation: act(a) = (a > 3) ? 3 : a[1:0].
  - It is applied to the acc-next value on each neuron's last step.
  - The result is written to that neuron's f register, or to out_y, on the same edge.
- Config writes:
  - Applied in IDLE and DONE.
  - In RUN a write is dropped and cfg_err pulses on the next cycle.
  - Addresses 17..31 are a no-op with no error.
- out_y and out_valid hold stable while out_ready is low.
- No new input is accepted in DONE.
- Synchronous rst, in any state:
  - State → IDLE.
  - All weights, biases, f1..f5, acc, and latched x → 0.
  - out_y=0, out_valid=0, busy=0, cfg_err=0, in_ready=1 the cycle after rst deasserts.
  - An in-flight inference is discarded.

## Timing
- Latency: out_valid rises 11 cycles after the accepting edge (on the step-10 edge).
- Minimum initiation interval is 13 cycles: accept, 11 RUN cycles, 1 DONE cycle with out_ready already high.
- in_ready is a registered-state decode (IDLE).
- If in_valid and rst are high in the same cycle, rst wins and the input is not accepted.
- A config write on the accepting edge (IDLE) is applied, and the new value is used by the inference.
- cfg_err fires only for writes sampled in RUN, including on the step-10 edge.

## Configuration
- NN_SEQ_PERF_EN defined:
  - Adds output perf_count[15:0].
  - Increments on each out_valid&out_ready and wraps 0xFFFF→0.
  - Cleared by rst.
- NN_SEQ_PERF_EN undefined: no counter logic and no perf_count port; all other behaviour is identical.

## Test plan
- Pass-through test:
  - Setup: w1=w2=1, w11=1, w01=1, all other weights 0, all biases 0; x1=2, x2=3.
  - Expected: f1=2, f2=3, f3=2, f4=f5=0, y=2; out_valid 11 cycles after accept.
- Bias-only test:
  - Setup: all weights 0, b6=2, any x.
  - Expected: y=2.
  - Setup: b6=3, b3=15.
  - Expected: y=3.
- Saturation test:
  - Setup: all weights 3, all biases 15, x1=x2=3.
  - Expected: every f=3, y=3, with no wrap.
- Backpressure test:
  - Hold out_ready=0 for 5 cycles after out_valid.
  - Expected: out_y stable, in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Busy config write:
  - Write w01=0 at step 4.
  - Expected: cfg_err pulses once, w01 unchanged, result unaffected.
  - Repeat the write in IDLE.
  - Expected: it takes effect and cfg_err=0.
- Mid-run reset:
  - Assert rst at step 6.
  - Expected: out_valid never rises, all config reads back as 0, next inference with all zero config gives y=0.
  - With NN_SEQ_PERF_EN, 3 completed inferences give perf_count=3.

Source files
------------

// File: rtl/nn_seq_controller_if.sv
// rtl/nn_seq_controller_if.sv - config bus and input/output stream handshakes for nn_seq_controller
interface nn_seq_controller_if;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       cfg_err;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_x1;
    logic [1:0] in_x2;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_y;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_x1, in_x2, out_ready,
        input  cfg_err, in_ready, out_valid, out_y
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_x1, in_x2, out_ready,
        output cfg_err, in_ready, out_valid, out_y
    );
endinterface

// File: rtl/nn_seq_controller.sv
// rtl/nn_seq_controller.sv - sequenced 2-3-1 network on one shared MAC neuron, 11 steps per inference
// Optional NN_SEQ_PERF_EN adds a 16-bit completed-inference counter (perf_count).
module nn_seq_controller (
    input  logic clk,
    input  logic rst,
    nn_seq_controller_if.slave bus,
    output logic busy
`ifdef NN_SEQ_PERF_EN
    ,
    output logic [15:0] perf_count
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] step;
    logic [1:0] x1, x2;
    logic [1:0] f1, f2, f3, f4, f5;
    logic [1:0] y_q;
    logic [5:0] acc, acc_nxt;
    logic       err_q;
    logic [1:0] w [0:10];
    logic [3:0] b [0:5];

    logic [1:0] op_a, op_w;
    logic [3:0] op_b;
    logic       first, last;
    logic [3:0] prod;
    logic [1:0] act;
    logic [2:0] bias_idx;
    logic       accept, handoff;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign handoff  = (state == DONE) && bus.out_ready;
    assign bias_idx = 3'(cfg_addr_minus_11(bus.cfg_addr));

    function automatic logic [4:0] cfg_addr_minus_11(input logic [4:0] a);
        return a - 5'd11;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (step == 4'd10) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        busy          = (state == RUN);
        bus.out_y     = y_q;
        bus.cfg_err   = err_q;
    end

    // Operand schedule: the first step of each neuron seeds acc with its bias.
    always_comb begin
        op_a  = 2'd0;
        op_w  = 2'd0;
        op_b  = 4'd0;
        first = 1'b0;
        last  = 1'b0;
        case (step)
            4'd0:  begin op_a = x1; op_w = w[0];  op_b = b[0]; first = 1'b1; last = 1'b1; end
            4'd1:  begin op_a = x2; op_w = w[1];  op_b = b[1]; first = 1'b1; last = 1'b1; end
            4'd2:  begin op_a = f1; op_w = w[2];  op_b = b[2]; first = 1'b1; end
            4'd3:  begin op_a = f2; op_w = w[5];  last = 1'b1; end
            4'd4:  begin op_a = f1; op_w = w[3];  op_b = b[3]; first = 1'b1; end
            4'd5:  begin op_a = f2; op_w = w[6];  last = 1'b1; end
            4'd6:  begin op_a = f1; op_w = w[4];  op_b = b[4]; first = 1'b1; end
            4'd7:  begin op_a = f2; op_w = w[7];  last = 1'b1; end
            4'd8:  begin op_a = f3; op_w = w[8];  op_b = b[5]; first = 1'b1; end
            4'd9:  begin op_a = f4; op_w = w[9];  end
            4'd10: begin op_a = f5; op_w = w[10]; last = 1'b1; end
            default: ;
        endcase
        prod    = {2'b00, op_a} * {2'b00, op_w};
        acc_nxt = first ? ({2'b00, op_b} + {2'b00, prod}) : (acc + {2'b00, prod});
        act     = (acc_nxt > 6'd3) ? 2'd3 : acc_nxt[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step  <= 4'd0;
            x1    <= 2'd0;
            x2    <= 2'd0;
            f1    <= 2'd0;
            f2    <= 2'd0;
            f3    <= 2'd0;
            f4    <= 2'd0;
            f5    <= 2'd0;
            y_q   <= 2'd0;
            acc   <= 6'd0;
            err_q <= 1'b0;
            for (int i = 0; i < 11; i++) w[i] <= 2'd0;
            for (int i = 0; i < 6; i++)  b[i] <= 4'd0;
        end else begin
            err_q <= bus.cfg_we && (state == RUN);
            if (bus.cfg_we && (state != RUN)) begin
                if (bus.cfg_addr < 5'd11)      w[bus.cfg_addr[3:0]] <= bus.cfg_data[1:0];
                else if (bus.cfg_addr < 5'd17) b[bias_idx]          <= bus.cfg_data;
            end
            if (accept) begin
                x1   <= bus.in_x1;
                x2   <= bus.in_x2;
                step <= 4'd0;
            end
            if (state == RUN) begin
                acc  <= acc_nxt;
                step <= step + 4'd1;
                if (last) begin
                    case (step)
                        4'd0:    f1  <= act;
                        4'd1:    f2  <= act;
                        4'd3:    f3  <= act;
                        4'd5:    f4  <= act;
                        4'd7:    f5  <= act;
                        default: y_q <= act;
                    endcase
                end
            end
        end
    end

`ifdef NN_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)          perf_count <= 16'd0;
        else if (handoff) perf_count <= perf_count + 16'd1;
    end
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif
endmodule

// File: tb/tb_nn_seq_controller.sv
// tb/tb_nn_seq_controller.sv - directed self-checking bench for nn_seq_controller
module tb_nn_seq_controller;
    logic clk;
    logic rst;
    logic busy;
    int   errors;
    int   checks;
`ifdef NN_SEQ_PERF_EN
    logic [15:0] perf_count;
`endif

    nn_seq_controller_if bus ();

    nn_seq_controller dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
`ifdef NN_SEQ_PERF_EN
        ,
        .perf_count (perf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [4:0] addr, input logic [3:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int a = 0; a < 17; a++) set_cfg(5'(a), 4'd0);
    endtask

    task automatic start(input logic [1:0] x1, input logic [1:0] x2);
        bus.in_valid = 1'b1;
        bus.in_x1    = x1;
        bus.in_x2    = x2;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [1:0] y, output int waited);
        waited = 0;
        while (!bus.out_valid && waited < 30) begin
            tick();
            waited++;
        end
        if (!bus.out_valid) check("out_valid_timeout", 16'd0, 16'd1);
        y = bus.out_y;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_after_take", 16'(bus.in_ready), 16'd1);
    endtask

    task automatic run_inf(input string tag, input logic [1:0] x1, input logic [1:0] x2,
                           input logic [1:0] exp_y);
        logic [1:0] y;
        int n;
        start(x1, x2);
        wait_result(y, n);
        check({tag, "_latency"}, 16'(n), 16'd11);
        check({tag, "_y"}, 16'(y), 16'(exp_y));
        take_result();
    endtask

    initial begin
        logic [1:0] y;
        logic [1:0] y_held;
        int n;
        logic saw_valid;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = 5'd0;
        bus.cfg_data = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_x1 = 2'd0;
        bus.in_x2 = 2'd0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("rst_in_ready", 16'(bus.in_ready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_out_y", 16'(bus.out_y), 16'd0);
        check("rst_cfg_err", 16'(bus.cfg_err), 16'd0);

        // Pass-through: w1=w2=w11=w01=1 -> f1=2, f2=3, f3=2, y=2
        set_cfg(5'd0, 4'd1);
        set_cfg(5'd1, 4'd1);
        set_cfg(5'd2, 4'd1);
        set_cfg(5'd8, 4'd1);
        start(2'd2, 2'd3);
        check("run_busy", 16'(busy), 16'd1);
        check("run_in_ready", 16'(bus.in_ready), 16'd0);
        wait_result(y, n);
        check("pass_latency", 16'(n), 16'd11);
        check("pass_y", 16'(y), 16'd2);
        check("done_busy", 16'(busy), 16'd0);
        take_result();

        // Backpressure: result held for 5 cycles of out_ready=0
        start(2'd2, 2'd3);
        wait_result(y_held, n);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_y", 16'(bus.out_y), 16'(y_held));
            check("bp_out_valid", 16'(bus.out_valid), 16'd1);
            check("bp_in_ready", 16'(bus.in_ready), 16'd0);
        end
        take_result();
        check("bp_out_valid_clr", 16'(bus.out_valid), 16'd0);

        // Busy write of w01=0 at step 4 is dropped
        start(2'd2, 2'd3);
        repeat (4) tick();
        set_cfg(5'd8, 4'd0);
        check("busy_cfg_err", 16'(bus.cfg_err), 16'd1);
        tick();
        check("busy_cfg_err_pulse", 16'(bus.cfg_err), 16'd0);
        wait_result(y, n);
        check("busy_latency", 16'(n + 6), 16'd11);
        check("busy_y", 16'(y), 16'd2);
        take_result();
        set_cfg(5'd8, 4'd0);
        check("idle_cfg_err", 16'(bus.cfg_err), 16'd0);
        set_cfg(5'd20, 4'd7);
        check("ignored_addr_err", 16'(bus.cfg_err), 16'd0);
        run_inf("w01_zero", 2'd2, 2'd3, 2'd0);

        // Bias only
        clear_cfg();
        set_cfg(5'd16, 4'd2);
        run_inf("bias6", 2'd1, 2'd2, 2'd2);
        set_cfg(5'd16, 4'd3);
        set_cfg(5'd13, 4'd15);
        run_inf("bias6_b3", 2'd3, 2'd0, 2'd3);

        // Saturation: acc peaks at 42, act -> 3
        for (int a = 0; a < 11; a++) set_cfg(5'(a), 4'd3);
        for (int a = 11; a < 17; a++) set_cfg(5'(a), 4'd15);
        run_inf("sat", 2'd3, 2'd3, 2'd3);

        // Mid-run reset at step 6
        start(2'd3, 2'd3);
        repeat (6) tick();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("mrst_in_ready", 16'(bus.in_ready), 16'd1);
        check("mrst_busy", 16'(busy), 16'd0);
        check("mrst_out_y", 16'(bus.out_y), 16'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (bus.out_valid) saw_valid = 1'b1;
            tick();
        end
        check("mrst_no_valid", 16'(saw_valid), 16'd0);
        run_inf("mrst_zero_cfg", 2'd3, 2'd3, 2'd0);
        run_inf("mrst_zero_cfg2", 2'd2, 2'd1, 2'd0);
        run_inf("mrst_zero_cfg3", 2'd1, 2'd3, 2'd0);
`ifdef NN_SEQ_PERF_EN
        check("perf_count", perf_count, 16'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
